mem_region_decoder: RTL and testbench

- Registered, parametrised address decoder between the MIPS core's data port and the memory subsystem.
- Classifies each request into one of four targets: internal RAM, memory-mapped I/O, external memory, or error.
- Rebases internal/I/O addresses to region offsets and inserts programmable wait states for external accesses.
- Uses a valid/ready handshake on both the request side and the response side.

---
 rtl/mem_region_decoder.sv | 220 ++++++++++++++++++++++
 tb/tb_mem_region_decoder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_region_decoder.sv
// mem_region_decoder: registered address decoder between the core data port
// and the memory subsystem. Each accepted request is classified as internal
// RAM, memory-mapped I/O, external memory or error (misaligned). Internal and
// I/O addresses are rebased to region offsets. External accesses are delayed
// by EXT_WAIT cycles before the response is presented.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   req_valid/ready  request handshake; req_addr byte address, req_we write
//   rsp_valid/ready  response handshake
//   rsp_addr         translated address
//   rsp_sel          00 internal, 01 I/O, 10 external, 11 error
//   rsp_we, rsp_err  registered write flag, misaligned flag
//   cs_int           internal-RAM select, qualified by rsp_valid
//
// Optional feature, macro DECODE_STATS_EN: adds 16-bit saturating hit
// counters stat_int, stat_io, stat_ext, stat_err, bumped on each response
// handshake for the matching target.
module mem_region_decoder #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] INT_BASE = 32'h0000_1000,
  parameter logic [ADDR_W-1:0] INT_SIZE = 32'h0000_0400,
  parameter logic [ADDR_W-1:0] IO_BASE  = 32'h0000_FF00,
  parameter logic [ADDR_W-1:0] IO_SIZE  = 32'h0000_0100,
  parameter int unsigned       EXT_WAIT = 3
) (
`ifdef DECODE_STATS_EN
  output logic [15:0]       stat_int,
  output logic [15:0]       stat_io,
  output logic [15:0]       stat_ext,
  output logic [15:0]       stat_err,
`endif
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [1:0]        rsp_sel,
  output logic              rsp_we,
  output logic              rsp_err,
  output logic              cs_int
);

  localparam int unsigned AW1   = ADDR_W + 1;
  localparam int unsigned CNT_W = 4;

  // Region ends computed one bit wider so a region touching the top of the
  // address space does not wrap to zero.
  localparam logic [AW1-1:0] INT_END = AW1'(INT_BASE) + AW1'(INT_SIZE);
  localparam logic [AW1-1:0] IO_END  = AW1'(IO_BASE) + AW1'(IO_SIZE);

  localparam bit              HAS_WAIT  = (EXT_WAIT != 0);
  localparam logic [CNT_W-1:0] WAIT_LOAD = HAS_WAIT ? CNT_W'(EXT_WAIT - 1) : '0;

  localparam logic [1:0] SEL_INT = 2'b00;
  localparam logic [1:0] SEL_IO  = 2'b01;
  localparam logic [1:0] SEL_EXT = 2'b10;
  localparam logic [1:0] SEL_ERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ADDR_W-1:0]  rsp_addr_q, rsp_addr_d;
  logic [1:0]         rsp_sel_q, rsp_sel_d;
  logic               rsp_we_q, rsp_we_d;
  logic               rsp_err_q, rsp_err_d;
  logic               cs_int_q, cs_int_d;

  logic [1:0]         dec_sel;
  logic [ADDR_W-1:0]  dec_addr;
  logic               dec_err;
  logic [AW1-1:0]     addr_ext;

  // Address classification; misaligned beats every region, internal beats I/O.
  always_comb begin
    addr_ext = AW1'(req_addr);
    dec_sel  = SEL_EXT;
    dec_addr = req_addr;
    dec_err  = 1'b0;
    if (req_addr[1:0] != 2'b00) begin
      dec_sel = SEL_ERR;
      dec_err = 1'b1;
    end else if ((req_addr >= INT_BASE) && (addr_ext < INT_END)) begin
      dec_sel  = SEL_INT;
      dec_addr = req_addr - INT_BASE;
    end else if ((req_addr >= IO_BASE) && (addr_ext < IO_END)) begin
      dec_sel  = SEL_IO;
      dec_addr = req_addr - IO_BASE;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_addr_d  = rsp_addr_q;
    rsp_sel_d   = rsp_sel_q;
    rsp_we_d    = rsp_we_q;
    rsp_err_d   = rsp_err_q;
    cs_int_d    = cs_int_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          rsp_addr_d  = dec_addr;
          rsp_sel_d   = dec_sel;
          rsp_we_d    = req_we;
          rsp_err_d   = dec_err;
          req_ready_d = 1'b0;
          if ((dec_sel == SEL_EXT) && HAS_WAIT) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            cs_int_d    = (dec_sel == SEL_INT);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          cs_int_d    = (rsp_sel_q == SEL_INT);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          cs_int_d    = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
        cs_int_d    = 1'b0;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_sel_q   <= SEL_INT;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      cs_int_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_addr_q  <= rsp_addr_d;
      rsp_sel_q   <= rsp_sel_d;
      rsp_we_q    <= rsp_we_d;
      rsp_err_q   <= rsp_err_d;
      cs_int_q    <= cs_int_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_addr  = rsp_addr_q;
  assign rsp_sel   = rsp_sel_q;
  assign rsp_we    = rsp_we_q;
  assign rsp_err   = rsp_err_q;
  assign cs_int    = cs_int_q;

`ifdef DECODE_STATS_EN
  logic [15:0] stat_int_q, stat_io_q, stat_ext_q, stat_err_q;

  // Saturating per-target hit counters, bumped on response handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_int_q <= '0;
      stat_io_q  <= '0;
      stat_ext_q <= '0;
      stat_err_q <= '0;
    end else if (rsp_valid_q && rsp_ready) begin
      unique case (rsp_sel_q)
        SEL_INT: if (stat_int_q != 16'hFFFF) stat_int_q <= stat_int_q + 16'd1;
        SEL_IO:  if (stat_io_q  != 16'hFFFF) stat_io_q  <= stat_io_q  + 16'd1;
        SEL_EXT: if (stat_ext_q != 16'hFFFF) stat_ext_q <= stat_ext_q + 16'd1;
        default: if (stat_err_q != 16'hFFFF) stat_err_q <= stat_err_q + 16'd1;
      endcase
    end
  end

  assign stat_int = stat_int_q;
  assign stat_io  = stat_io_q;
  assign stat_ext = stat_ext_q;
  assign stat_err = stat_err_q;
`else
  // Statistics disabled: no counters or stat ports are built.
`endif

endmodule

// File: tb/tb_mem_region_decoder.sv
module tb_mem_region_decoder;

  logic        clk;
  logic        rst;
  logic        req_valid, req_we, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid, rsp_ready, rsp_we, rsp_err, cs_int;
  logic [31:0] rsp_addr;
  logic [1:0]  rsp_sel;

  logic        rst5;
  logic        req_valid5, req_we5, req_ready5;
  logic [31:0] req_addr5;
  logic        rsp_valid5, rsp_ready5, rsp_we5, rsp_err5, cs_int5;
  logic [31:0] rsp_addr5;
  logic [1:0]  rsp_sel5;

`ifdef DECODE_STATS_EN
  logic [15:0] stat_int, stat_io, stat_ext, stat_err;
  logic [15:0] stat_int5, stat_io5, stat_ext5, stat_err5;
`endif

  int checks;
  int errors;

  mem_region_decoder u_dut (
`ifdef DECODE_STATS_EN
    .stat_int (stat_int),
    .stat_io  (stat_io),
    .stat_ext (stat_ext),
    .stat_err (stat_err),
`endif
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_addr  (rsp_addr),
    .rsp_sel   (rsp_sel),
    .rsp_we    (rsp_we),
    .rsp_err   (rsp_err),
    .cs_int    (cs_int)
  );

  mem_region_decoder #(.EXT_WAIT(5)) u_dut5 (
`ifdef DECODE_STATS_EN
    .stat_int (stat_int5),
    .stat_io  (stat_io5),
    .stat_ext (stat_ext5),
    .stat_err (stat_err5),
`endif
    .clk       (clk),
    .rst       (rst5),
    .req_valid (req_valid5),
    .req_addr  (req_addr5),
    .req_we    (req_we5),
    .req_ready (req_ready5),
    .rsp_valid (rsp_valid5),
    .rsp_ready (rsp_ready5),
    .rsp_addr  (rsp_addr5),
    .rsp_sel   (rsp_sel5),
    .rsp_we    (rsp_we5),
    .rsp_err   (rsp_err5),
    .cs_int    (cs_int5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  sel;
    logic [31:0] xaddr;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[13];
  int   exp_st[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on the EXT_WAIT=3 instance, checked against a vector.
  task automatic run_vec(input vec_t v, input int idx);
    int  lat;
    bit  rr_bad;
    string tag;
    tag = $sformatf("vec%0d", idx);
    req_addr  = v.addr;
    req_we    = v.we;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    check({tag, "_ready_idle"}, 64'(req_ready), 64'(1));
    tick();
    req_valid = 1'b0;
    req_addr  = 32'hDEAD_BEE0;
    req_we    = ~v.we;
    lat    = 1;
    rr_bad = 1'b0;
    while (!rsp_valid && lat < 30) begin
      if (req_ready) rr_bad = 1'b1;
      tick();
      lat++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(v.lat));
    check({tag, "_sel"}, 64'(rsp_sel), 64'(v.sel));
    check({tag, "_addr"}, 64'(rsp_addr), 64'(v.xaddr));
    check({tag, "_err"}, 64'(rsp_err), 64'(v.err));
    check({tag, "_we"}, 64'(rsp_we), 64'(v.we));
    check({tag, "_cs_int"}, 64'(cs_int), 64'(v.sel == 2'b00));
    check({tag, "_ready_busy"}, 64'(rr_bad | req_ready), 64'(0));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_st[v.sel]++;
    check({tag, "_valid_done"}, 64'(rsp_valid), 64'(0));
    check({tag, "_ready_done"}, 64'(req_ready), 64'(1));
    check({tag, "_cs_done"}, 64'(cs_int), 64'(0));
  endtask

  initial begin
    int          lat;
    int          stray;
    logic [31:0] h_addr;
    logic [1:0]  h_sel;
    logic        h_we;

    checks = 0;
    errors = 0;
    for (int i = 0; i < 4; i++) exp_st[i] = 0;

    vecs[0]  = '{32'h0000_1004, 1'b0, 2'b00, 32'h0000_0004, 1'b0, 1};
    vecs[1]  = '{32'h0000_13FC, 1'b1, 2'b00, 32'h0000_03FC, 1'b0, 1};
    vecs[2]  = '{32'h0000_1400, 1'b0, 2'b10, 32'h0000_1400, 1'b0, 4};
    vecs[3]  = '{32'h0000_0FFC, 1'b1, 2'b10, 32'h0000_0FFC, 1'b0, 4};
    vecs[4]  = '{32'h0000_FF10, 1'b1, 2'b01, 32'h0000_0010, 1'b0, 1};
    vecs[5]  = '{32'h0000_FF00, 1'b0, 2'b01, 32'h0000_0000, 1'b0, 1};
    vecs[6]  = '{32'h0000_FFFC, 1'b0, 2'b01, 32'h0000_00FC, 1'b0, 1};
    vecs[7]  = '{32'h0001_0000, 1'b0, 2'b10, 32'h0001_0000, 1'b0, 4};
    vecs[8]  = '{32'h0000_1002, 1'b0, 2'b11, 32'h0000_1002, 1'b1, 1};
    vecs[9]  = '{32'h0000_FF01, 1'b1, 2'b11, 32'h0000_FF01, 1'b1, 1};
    vecs[10] = '{32'h0000_2000, 1'b0, 2'b10, 32'h0000_2000, 1'b0, 4};
    vecs[11] = '{32'hFFFF_FFFC, 1'b1, 2'b10, 32'hFFFF_FFFC, 1'b0, 4};
    vecs[12] = '{32'h0000_0000, 1'b0, 2'b10, 32'h0000_0000, 1'b0, 4};

    rst = 1'b1;  rst5 = 1'b1;
    req_valid = 1'b0;  req_addr = '0;  req_we = 1'b0;  rsp_ready = 1'b0;
    req_valid5 = 1'b0; req_addr5 = '0; req_we5 = 1'b0; rsp_ready5 = 1'b0;
    tick();
    tick();

    // Reset values
    check("rst_req_ready", 64'(req_ready), 64'(1));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_addr", 64'(rsp_addr), 64'(0));
    check("rst_rsp_sel", 64'(rsp_sel), 64'(0));
    check("rst_rsp_we", 64'(rsp_we), 64'(0));
    check("rst_rsp_err", 64'(rsp_err), 64'(0));
    check("rst_cs_int", 64'(cs_int), 64'(0));
`ifdef DECODE_STATS_EN
    check("rst_stats", 64'({stat_int, stat_io, stat_ext, stat_err}), 64'(0));
`endif
    rst = 1'b0;
    rst5 = 1'b0;
    tick();

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Backpressure: response held, new request ignored while in RESP
    req_addr = 32'h0000_1008; req_we = 1'b1; req_valid = 1'b1;
    tick();
    req_addr = 32'h0000_FF04; req_we = 1'b0;
    check("bp_valid", 64'(rsp_valid), 64'(1));
    h_addr = rsp_addr; h_sel = rsp_sel; h_we = rsp_we;
    check("bp_addr0", 64'(h_addr), 64'(32'h8));
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("bp_hold_valid%0d", c), 64'(rsp_valid), 64'(1));
      check($sformatf("bp_hold_addr%0d", c), 64'(rsp_addr), 64'(h_addr));
      check($sformatf("bp_hold_sel%0d", c), 64'(rsp_sel), 64'(h_sel));
      check($sformatf("bp_hold_we%0d", c), 64'(rsp_we), 64'(h_we));
      check($sformatf("bp_hold_ready%0d", c), 64'(req_ready), 64'(0));
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_st[0]++;
    check("bp_release_valid", 64'(rsp_valid), 64'(0));
    check("bp_release_ready", 64'(req_ready), 64'(1));
    // Pending request is taken only now that the decoder is back in IDLE
    tick();
    req_valid = 1'b0;
    check("bp_next_valid", 64'(rsp_valid), 64'(1));
    check("bp_next_sel", 64'(rsp_sel), 64'(1));
    check("bp_next_addr", 64'(rsp_addr), 64'(4));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_st[1]++;
    check("bp_next_done", 64'(req_ready), 64'(1));

`ifdef DECODE_STATS_EN
    check("stat_int", 64'(stat_int), 64'(exp_st[0]));
    check("stat_io", 64'(stat_io), 64'(exp_st[1]));
    check("stat_ext", 64'(stat_ext), 64'(exp_st[2]));
    check("stat_err", 64'(stat_err), 64'(exp_st[3]));
`endif

    // EXT_WAIT=5 latency
    req_addr5 = 32'h0000_3000; req_valid5 = 1'b1;
    tick();
    req_valid5 = 1'b0;
    lat = 1;
    while (!rsp_valid5 && lat < 30) begin
      tick();
      lat++;
    end
    check("w5_latency", 64'(lat), 64'(6));
    check("w5_sel", 64'(rsp_sel5), 64'(2));
    rsp_ready5 = 1'b1;
    tick();
    rsp_ready5 = 1'b0;

    // Reset during WAIT
    req_addr5 = 32'h0000_2000; req_valid5 = 1'b1;
    tick();
    req_valid5 = 1'b0;
    tick();
    tick();
    check("w5_in_wait_ready", 64'(req_ready5), 64'(0));
    rst5 = 1'b1;
    #2;
    check("w5_rst_wait_valid", 64'(rsp_valid5), 64'(0));
    check("w5_rst_wait_ready", 64'(req_ready5), 64'(1));
    check("w5_rst_wait_sel", 64'(rsp_sel5), 64'(0));
    check("w5_rst_wait_addr", 64'(rsp_addr5), 64'(0));
`ifdef DECODE_STATS_EN
    check("w5_rst_stats", 64'({stat_int5, stat_io5, stat_ext5, stat_err5}), 64'(0));
`endif
    tick();
    rst5 = 1'b0;
    stray = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rsp_valid5) stray++;
    end
    check("w5_no_stray_wait", 64'(stray), 64'(0));

    // Reset while a response is being presented
    req_addr5 = 32'h0000_1000; req_valid5 = 1'b1;
    tick();
    req_valid5 = 1'b0;
    check("w5_resp_valid", 64'(rsp_valid5), 64'(1));
    check("w5_resp_cs", 64'(cs_int5), 64'(1));
    rst5 = 1'b1;
    #2;
    check("w5_rst_resp_valid", 64'(rsp_valid5), 64'(0));
    check("w5_rst_resp_cs", 64'(cs_int5), 64'(0));
    check("w5_rst_resp_ready", 64'(req_ready5), 64'(1));
    tick();
    rst5 = 1'b0;
    rsp_ready5 = 1'b1;
    stray = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rsp_valid5) stray++;
    end
    rsp_ready5 = 1'b0;
    check("w5_no_stray_resp", 64'(stray), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
